wb_queue: RTL and testbench
===========================

// Module: wb_queue
// PURPOSE
//  Writeback queue directly upstream of the 4x8-bit register bank (regBank). Accepts register
//  writes (target index + 8-bit result) from the execute stage via a valid/ready handshake,
//  buffers them in order, and drains one per cycle onto the bank's WR/rs/data inputs.
//  Publishes a per-register busy scoreboard so the decoder can stall on read-after-write hazards.
// PARAMETERS
//  DEPTH   4  queue entries; power of two, >= 2
//  DATA_W  8  result width; must match the register bank
//  REG_AW  2  register index width; the bank has 2**REG_AW registers
// PORTS
//  clk       in   1         rising-edge clock
//  rst_n     in   1         asynchronous reset, active low
//  in_valid  in   1         execute stage presents a write
//  in_ready  out  1         queue can accept; a transfer occurs when in_valid && in_ready at posedge
//  in_rs     in   REG_AW    target register of the offered write
//  in_data   in   DATA_W    value of the offered write
//  wb_stall  in   1         hold: no pop this cycle
//  flush     in   1         synchronous discard of all pending writes
//  WR        out  1         register-bank write enable (registered)
//  rs        out  REG_AW    register-bank select (registered)
//  data      out  DATA_W    register-bank write data (registered)
//  busy      out  2**REG_AW bit r=1: a write to register r is queued or on WR this cycle
//  count     out  clog2(DEPTH)+1  number of queued entries, excluding the one on WR
//  fwd_rs    in   REG_AW    bypass lookup index
//  fwd_hit   out  1         bypass: pending write to fwd_rs exists
//  fwd_data  out  DATA_W    bypass: value of the youngest pending write to fwd_rs
// BEHAVIOUR
//  - Reset (rst_n=0, takes effect immediately): WR=0, rs=0, data=0, count=0, busy=0, fwd_hit=0,
//    fwd_data=0, in_ready=1; pointers cleared; queue contents discarded, including mid-drain.
//  - in_ready = (count < DEPTH), derived from registered state only; no combinational path
//    from in_valid or wb_stall. A full queue does not accept, even when popping in the same cycle.
//  - Push: on accept, {in_rs, in_data} is written at the tail; tail wraps modulo DEPTH.
//  - Pop: at each posedge with count>0, !wb_stall, and !flush: head goes to {rs, data}, WR=1 for
//    exactly that cycle; head wraps modulo DEPTH. Otherwise WR=0; rs/data hold their last values.
//  - Latency: a write accepted into an empty queue at edge T appears with WR=1 after edge T+1.
//    Sustained throughput is 1 write/cycle.
//  - Simultaneous push and pop: count is unchanged; FIFO order is preserved. Writes to the same
//    register are never coalesced, and each one reaches the bank in order.
//  - busy: per-register counters of pending writes (queued + on WR). Increment on push and
//    decrement when the WR cycle ends. busy[r] = (counter[r] != 0). A push and a retire to the
//    same r in one cycle leave counter[r] unchanged.
//  - flush: takes priority over push and pop. It empties the queue, forces WR=0 at the next edge,
//    and clears busy. An in_valid in the flush cycle is dropped.
//  - wb_stall with count=0 has no effect. wb_stall never blocks a push when count<DEPTH.
// CONFIGURATION
//  WB_BYPASS_EN defined: fwd_hit/fwd_data are combinational. The search covers the entry on WR
//    (oldest) and then queued entries from head to tail. The youngest entry with matching rs wins.
//  WB_BYPASS_EN undefined: the ports remain; fwd_hit=0 and fwd_data=0 constantly; no search logic.
// TESTING
//  1 reset: hold rst_n=0 -> WR=0, rs=0, data=0, busy=4'b0000, in_ready=1, count=0.
//  2 single write: push {rs=2'b01, data=8'h2B} at edge T -> WR=1, rs=1, data=8'h2B after T+1;
//    busy=4'b0010 until WR drops, then 4'b0000.
//  3 full and order: wb_stall=1, push 8'h38, 8'h2B, 8'h23, 8'h03 to r0..r3 -> count=4, in_ready=0;
//    a 5th in_valid is not accepted. Release wb_stall -> 4 consecutive WR cycles in push order.
//  4 same register: push r2=8'h11 and then r2=8'h22 -> two WR cycles, 8'h11 then 8'h22;
//    busy[2] stays 1 until the second WR cycle ends.
//  5 flush and reset mid-drain: flush with 3 queued -> WR=0 next cycle, count=0, busy=0.
//    rst_n low during a WR cycle -> WR=0 with no clock edge.
//  6 bypass (WB_BYPASS_EN): queue r3=8'hC3 and then r3=8'hFB; fwd_rs=3 -> fwd_hit=1,
//    fwd_data=8'hFB. Without the macro -> fwd_hit=0.

Source files
------------

// File: rtl/wb_queue.sv
// Writeback queue feeding the register bank, with a per-register busy scoreboard.
// Optional bypass search of pending writes enabled by defining WB_BYPASS_EN.
module wb_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int REG_AW = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [REG_AW-1:0]      in_rs,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   wb_stall,
  input  logic                   flush,
  output logic                   WR,
  output logic [REG_AW-1:0]      rs,
  output logic [DATA_W-1:0]      data,
  output logic [2**REG_AW-1:0]   busy,
  output logic [$clog2(DEPTH):0] count,
  input  logic [REG_AW-1:0]      fwd_rs,
  output logic                   fwd_hit,
  output logic [DATA_W-1:0]      fwd_data
);

  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int NREG = 2**REG_AW;
  localparam int BW   = $clog2(DEPTH + 2);

  logic [REG_AW-1:0] mem_rs   [DEPTH];
  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [AW-1:0]     head;
  logic [AW-1:0]     tail;
  logic [BW-1:0]     pend [NREG];

  logic push;
  logic pop;

  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid && in_ready && !flush;
  assign pop      = (count != '0) && !wb_stall && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_rs[tail]   <= in_rs;
      mem_data[tail] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push)
        tail <= tail + AW'(1);
      if (pop)
        head <= head + AW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (pop && !push)
        count <= count - CW'(1);
    end
  end

  // Bank-side registers; rs/data hold their last value when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WR   <= 1'b0;
      rs   <= '0;
      data <= '0;
    end else begin
      WR <= pop;
      if (pop) begin
        rs   <= mem_rs[head];
        data <= mem_data[head];
      end
    end
  end

  // Pending-write counters: +1 on push, -1 as the WR cycle retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++)
        pend[r] <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        if (flush)
          pend[r] <= '0;
        else if ((push && in_rs == REG_AW'(r))
                 && !(WR && rs == REG_AW'(r)))
          pend[r] <= pend[r] + BW'(1);
        else if ((WR && rs == REG_AW'(r))
                 && !(push && in_rs == REG_AW'(r)))
          pend[r] <= pend[r] - BW'(1);
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int r = 0; r < NREG; r++)
      busy[r] = (pend[r] != '0);
  end

`ifdef WB_BYPASS_EN
  logic [AW-1:0] idx;

  // Oldest first, so a later match overrides: youngest wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    if (WR && rs == fwd_rs) begin
      fwd_hit  = 1'b1;
      fwd_data = data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if (CW'(i) < count && mem_rs[idx] == fwd_rs) begin
        fwd_hit  = 1'b1;
        fwd_data = mem_data[idx];
      end
    end
  end
`else
  logic unused_fwd;

  assign unused_fwd = ^fwd_rs;
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Directed self-checking bench for wb_queue.
// Bypass expectations follow WB_BYPASS_EN.
module tb_wb_queue;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_rs;
  logic [7:0] in_data;
  logic       wb_stall;
  logic       flush;
  logic       WR;
  logic [1:0] rs;
  logic [7:0] data;
  logic [3:0] busy;
  logic [2:0] count;
  logic [1:0] fwd_rs;
  logic       fwd_hit;
  logic [7:0] fwd_data;

  int checks = 0;
  int errors = 0;

  wb_queue dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rs    (in_rs),
    .in_data  (in_data),
    .wb_stall (wb_stall),
    .flush    (flush),
    .WR       (WR),
    .rs       (rs),
    .data     (data),
    .busy     (busy),
    .count    (count),
    .fwd_rs   (fwd_rs),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bank(input string tag, input bit wr,
                      input logic [1:0] r, input logic [7:0] d);
    chk({tag, "_wr"}, 32'(WR), 32'(wr));
    chk({tag, "_rs"}, 32'(rs), 32'(r));
    chk({tag, "_data"}, 32'(data), 32'(d));
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_rs    = '0;
    in_data  = '0;
    wb_stall = 1'b0;
    flush    = 1'b0;
    fwd_rs   = '0;
    #12;
    bank("rst", 1'b0, 2'd0, 8'h00);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h1);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_fwd", 32'(fwd_hit), 32'h0);
    rst_n = 1'b1;
    step();

    // single write
    in_valid = 1'b1; in_rs = 2'd1; in_data = 8'h2B;
    step();
    in_valid = 1'b0;
    chk("t2_count", 32'(count), 32'h1);
    chk("t2_busy0", 32'(busy), 32'h2);
    chk("t2_wr0", 32'(WR), 32'h0);
    step();
    bank("t2_pop", 1'b1, 2'd1, 8'h2B);
    chk("t2_busy1", 32'(busy), 32'h2);
    chk("t2_count1", 32'(count), 32'h0);
    step();
    bank("t2_idle", 1'b0, 2'd1, 8'h2B);
    chk("t2_busy2", 32'(busy), 32'h0);

    // fill under stall, then drain in order
    wb_stall = 1'b1;
    in_valid = 1'b1;
    in_rs = 2'd0; in_data = 8'h38; step();
    in_rs = 2'd1; in_data = 8'h2B; step();
    in_rs = 2'd2; in_data = 8'h23; step();
    in_rs = 2'd3; in_data = 8'h03; step();
    chk("t3_count", 32'(count), 32'h4);
    chk("t3_ready", 32'(in_ready), 32'h0);
    chk("t3_busy", 32'(busy), 32'hF);
    in_rs = 2'd0; in_data = 8'hFF; step();
    in_valid = 1'b0;
    chk("t3_nopush", 32'(count), 32'h4);
    chk("t3_wr_stall", 32'(WR), 32'h0);
    wb_stall = 1'b0;
    step(); bank("t3_p0", 1'b1, 2'd0, 8'h38);
    step(); bank("t3_p1", 1'b1, 2'd1, 8'h2B);
    step(); bank("t3_p2", 1'b1, 2'd2, 8'h23);
    step(); bank("t3_p3", 1'b1, 2'd3, 8'h03);
    step(); bank("t3_end", 1'b0, 2'd3, 8'h03);
    chk("t3_busy_end", 32'(busy), 32'h0);
    chk("t3_count_end", 32'(count), 32'h0);

    // same register twice
    in_valid = 1'b1; in_rs = 2'd2;
    in_data = 8'h11; step();
    in_data = 8'h22; step();
    in_valid = 1'b0;
    bank("t4_a", 1'b1, 2'd2, 8'h11);
    chk("t4_busy_a", 32'(busy), 32'h4);
    step();
    bank("t4_b", 1'b1, 2'd2, 8'h22);
    chk("t4_busy_b", 32'(busy), 32'h4);
    step();
    chk("t4_wr_end", 32'(WR), 32'h0);
    chk("t4_busy_end", 32'(busy), 32'h0);

    // bypass with three queued writes, then flush
    wb_stall = 1'b1;
    in_valid = 1'b1;
    in_rs = 2'd3; in_data = 8'hC3; step();
    in_rs = 2'd3; in_data = 8'hFB; step();
    in_rs = 2'd1; in_data = 8'h55; step();
    in_valid = 1'b0;
    chk("t6_count", 32'(count), 32'h3);
    fwd_rs = 2'd3; #1;
    chk("t6_hit3", 32'(fwd_hit), 32'(BYP));
    chk("t6_data3", 32'(fwd_data), BYP ? 32'hFB : 32'h0);
    fwd_rs = 2'd1; #1;
    chk("t6_hit1", 32'(fwd_hit), 32'(BYP));
    chk("t6_data1", 32'(fwd_data), BYP ? 32'h55 : 32'h0);
    fwd_rs = 2'd0; #1;
    chk("t6_hit0", 32'(fwd_hit), 32'h0);

    flush = 1'b1; wb_stall = 1'b0;
    in_valid = 1'b1; in_rs = 2'd0; in_data = 8'hEE;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_wr", 32'(WR), 32'h0);
    chk("t5_count", 32'(count), 32'h0);
    chk("t5_busy", 32'(busy), 32'h0);
    chk("t5_ready", 32'(in_ready), 32'h1);
    step();
    chk("t5_wr2", 32'(WR), 32'h0);
    chk("t5_busy2", 32'(busy), 32'h0);

    // entry on WR is visible to the bypass; reset kills it without a clock
    in_valid = 1'b1; in_rs = 2'd0; in_data = 8'h9A; step();
    in_valid = 1'b0; step();
    bank("t5_pre", 1'b1, 2'd0, 8'h9A);
    fwd_rs = 2'd0; #1;
    chk("t6_hitwr", 32'(fwd_hit), 32'(BYP));
    chk("t6_datawr", 32'(fwd_data), BYP ? 32'h9A : 32'h0);
    rst_n = 1'b0; #1;
    bank("t5_rst", 1'b0, 2'd0, 8'h00);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    chk("t5_rst_count", 32'(count), 32'h0);
    chk("t5_rst_fwd", 32'(fwd_hit), 32'h0);
    rst_n = 1'b1;
    step();
    chk("t5_post_wr", 32'(WR), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
